// File: rtl/pcm_up_ctrl_if.sv
// Sample/handshake bundle between the PCM rate detector and the upsampler.
// The slave modport is the controller; the master modport is the source/upsampler side.
interface pcm_up_ctrl_if;
  logic               in_strobe;
  logic signed [31:0] in_l;
  logic signed [31:0] in_r;
  logic               started;
  logic               start;
  logic [1:0]         source_type;
  logic signed [31:0] xl;
  logic signed [31:0] xr;
  logic               locked;
  logic               out_strobe;
  logic [7:0]         unlock_cnt;

  modport master (
    output in_strobe, in_l, in_r, started,
    input  start, source_type, xl, xr, locked, out_strobe, unlock_cnt
  );

  modport slave (
    input  in_strobe, in_l, in_r, started,
    output start, source_type, xl, xr, locked, out_strobe, unlock_cnt
  );
endinterface

// File: rtl/pcm_up_ctrl.sv
// Measures the incoming stereo sample period, locks onto one of four PCM rates,
// and then enables the upsampler and hands it held samples plus a 352.8 kHz phase strobe.
module pcm_up_ctrl #(
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 8,
  parameter int MISS_CNT = 2
) (
  input logic          mclk,
  input logic          reset,
  pcm_up_ctrl_if.slave bus
);
  localparam int              MW         = $clog2(LOCK_CNT + 1);
  localparam int              XW         = $clog2(MISS_CNT + 1);
  localparam logic [MW-1:0]   MATCH_LOCK = MW'(LOCK_CNT);
  localparam logic [XW-1:0]   MISS_DROP  = XW'(MISS_CNT);
  localparam logic [10:0]     PERIOD_SAT = 11'h7FF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQUIRE,
    S_LOCKED,
    S_FLUSH
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] rate;
  } class_t;

  // Nominal periods are 1024 >> rate mclk cycles; windows never overlap for sane TOL.
  function automatic class_t classify(input logic [10:0] period);
    class_t c;
    c = '{valid: 1'b0, rate: 2'b00};
    for (int k = 0; k < 4; k++) begin
      if (int'(period) >= (1024 >> k) - TOL && int'(period) <= (1024 >> k) + TOL) begin
        c.valid = 1'b1;
        c.rate  = 2'(k);
      end
    end
    return c;
  endfunction

  state_e             state_q,  state_d;
  logic [10:0]        period_q, period_d;
  logic [MW-1:0]      match_q,  match_d;
  logic [XW-1:0]      miss_q,   miss_d;
  logic [1:0]         cand_q,   cand_d;
  logic               flush_q,  flush_d;
  logic               start_q,  start_d;
  logic               locked_q, locked_d;
  logic [1:0]         src_q,    src_d;
  logic signed [31:0] xl_q,     xl_d;
  logic signed [31:0] xr_q,     xr_d;
  logic [7:0]         unlock_q, unlock_d;
  logic [6:0]         phase_q,  phase_d;
  class_t             cls;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can infer a latch.
    state_d  = state_q;
    match_d  = match_q;
    miss_d   = miss_q;
    cand_d   = cand_q;
    flush_d  = flush_q;
    start_d  = start_q;
    locked_d = locked_q;
    src_d    = src_q;
    xl_d     = xl_q;
    xr_d     = xr_q;
    unlock_d = unlock_q;
    cls      = classify(period_q);

    if (bus.in_strobe)              period_d = 11'd1;
    else if (period_q == PERIOD_SAT) period_d = period_q;
    else                             period_d = period_q + 11'd1;

    if (locked_q && bus.in_strobe) begin
      xl_d = bus.in_l;
      xr_d = bus.in_r;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_strobe) state_d = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        if (bus.in_strobe) begin
          if (!cls.valid) begin
            match_d = '0;
          end else if (cls.rate == cand_q) begin
            match_d = match_q + MW'(1);
          end else begin
            cand_d  = cls.rate;
            match_d = MW'(1);
          end
          if (match_d == MATCH_LOCK) begin
            state_d  = S_LOCKED;
            src_d    = cand_d;
            locked_d = 1'b1;
            miss_d   = '0;
          end
        end
      end
      S_LOCKED: begin
        start_d = 1'b1;
        // A stalled source looks like one bad period per saturated cycle.
        if (bus.in_strobe)
          miss_d = (cls.valid && cls.rate == src_q) ? '0 : miss_q + XW'(1);
        else if (period_q == PERIOD_SAT)
          miss_d = miss_q + XW'(1);
        if (miss_d == MISS_DROP) begin
          state_d  = S_FLUSH;
          start_d  = 1'b0;
          locked_d = 1'b0;
          xl_d     = '0;
          xr_d     = '0;
          flush_d  = 1'b0;
          if (unlock_q != 8'hFF) unlock_d = unlock_q + 8'd1;
        end
      end
      S_FLUSH: begin
        if (flush_q) begin
          state_d = S_ACQUIRE;
          match_d = '0;
        end else begin
          flush_d = 1'b1;
        end
      end
    endcase

    phase_d = (start_d && !start_q) ? 7'd0 : phase_q + 7'd1;
  end

  always_ff @(posedge mclk) begin
    // NOTE: the sample holding registers are reset too, so the upsampler never sees stale audio.
    if (reset) begin
      state_q  <= S_IDLE;
      period_q <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      cand_q   <= '0;
      flush_q  <= 1'b0;
      start_q  <= 1'b0;
      locked_q <= 1'b0;
      src_q    <= '0;
      xl_q     <= '0;
      xr_q     <= '0;
      unlock_q <= '0;
      phase_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      state_q  <= state_d;
      period_q <= period_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      cand_q   <= cand_d;
      flush_q  <= flush_d;
      start_q  <= start_d;
      locked_q <= locked_d;
      src_q    <= src_d;
      xl_q     <= xl_d;
      xr_q     <= xr_d;
      unlock_q <= unlock_d;
      phase_q  <= phase_d;
    end
  end

  assign bus.start       = start_q;
  assign bus.source_type = src_q;
  assign bus.xl          = xl_q;
  assign bus.xr          = xr_q;
  assign bus.locked      = locked_q;
  assign bus.unlock_cnt  = unlock_q;
  assign bus.out_strobe  = (phase_q == 7'd127) && bus.started;
endmodule
